// File: rtl/key_event_queue.sv
// Key event back-end: held-key bitmap, make/break event FIFO with first-word
// fall-through output, typematic auto-repeat generator and sticky overflow flag.
module key_event_queue #(
    parameter int CODE_W       = 9,
    parameter int DEPTH        = 8,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [CODE_W-1:0]        in_code,
    input  logic                     in_break,
    input  logic                     repeat_en,
    input  logic                     clr_overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CODE_W-1:0]        out_code,
    output logic                     out_break,
    output logic                     out_repeat,
    output logic [2**CODE_W-1:0]     key_down,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              brk;
        logic              rpt;
    } entry_t;

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RATE} rstate_t;

    entry_t            mem [DEPTH];
    entry_t            head, push_data;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       count;
    logic              held, accept, full, pop, room, push, drop, fire;

    rstate_t           state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [CODE_W-1:0] rpt_code, rpt_code_n;

    // Only a make of a released key or a break of a held key gets through.
    assign held   = key_down[in_code];
    assign accept = in_valid && (in_break ? held : !held);

    assign full      = (count == FULL_LVL);
    assign pop       = (count != '0) && out_ready;
    assign room      = !full || pop;
    assign push      = (accept || fire) && room;
    assign drop      = accept && !room;
    assign push_data = accept ? entry_t'{in_code, in_break, 1'b0}
                              : entry_t'{rpt_code, 1'b0, 1'b1};

    assign out_valid  = (count != '0);
    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign out_code   = head.code;
    assign out_break  = head.brk;
    assign out_repeat = head.rpt;
    assign level      = count;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rpt_code_n = rpt_code;
        fire       = 1'b0;
        if (!repeat_en) begin
            state_n = R_IDLE;
        end else if (accept && !in_break) begin
            rpt_code_n = in_code;
            cnt_n      = CW'(REPEAT_DELAY - 1);
            state_n    = R_DELAY;
        end else if (accept && in_code == rpt_code) begin
            state_n = R_IDLE;
        end else if (state != R_IDLE) begin
            if (cnt != '0) begin
                cnt_n = cnt - CW'(1);
            end else if (!accept) begin
                // A fire with no room is simply lost; the cadence still restarts.
                fire    = 1'b1;
                cnt_n   = CW'(REPEAT_RATE - 1);
                state_n = R_RATE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            key_down <= '0;
            overflow <= 1'b0;
            state    <= R_IDLE;
            cnt      <= '0;
            rpt_code <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (accept) key_down[in_code] <= !in_break;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
            state    <= state_n;
            cnt      <= cnt_n;
            rpt_code <= rpt_code_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: queue/timestamp reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_key_event_queue;

    localparam int CODE_W = 9;
    localparam int DEPTH  = 4;
    localparam int DELAY  = 20;
    localparam int RATE   = 5;

    logic              clk, rst_n, in_valid, in_break, repeat_en, clr_overflow, out_ready;
    logic [CODE_W-1:0] in_code, out_code;
    logic              out_valid, out_break, out_repeat, overflow;
    logic [511:0]      key_down;
    logic [2:0]        level;

    key_event_queue #(
        .CODE_W(CODE_W), .DEPTH(DEPTH), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
        .in_break(in_break), .repeat_en(repeat_en), .clr_overflow(clr_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_break(out_break), .out_repeat(out_repeat), .key_down(key_down),
        .level(level), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: event queue, bitmap, and next-fire timestamp for the tracked key.
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              brk;
        logic              rpt;
    } ent_t;

    ent_t              q[$];
    ent_t              m_ent, hd;
    logic [511:0]      m_kd;
    logic              m_ovf, m_ract, m_pop, m_acc, m_room, m_fire, m_drop;
    logic [CODE_W-1:0] m_rcode;
    int                m_cyc = 0;
    int                m_due;
    bit                live = 0;

    always @(posedge clk) begin
        m_cyc++;
        if (!rst_n) begin
            q.delete();
            m_kd   = '0;
            m_ovf  = 1'b0;
            m_ract = 1'b0;
            live   = 1;
        end else begin
            m_pop  = (q.size() != 0) && out_ready;
            m_acc  = in_valid && (in_break ? m_kd[in_code] : !m_kd[in_code]);
            m_room = (q.size() < DEPTH) || m_pop;
            m_drop = m_acc && !m_room;
            m_fire = 1'b0;
            if (!repeat_en) m_ract = 1'b0;
            else if (m_acc && !in_break) begin
                m_ract = 1'b1; m_rcode = in_code; m_due = m_cyc + DELAY;
            end else if (m_acc && m_ract && in_code == m_rcode) m_ract = 1'b0;
            else if (m_ract && m_cyc >= m_due) begin
                if (m_acc) m_due = m_cyc + 1;
                else begin m_fire = 1'b1; m_due = m_cyc + RATE; end
            end
            if (m_pop) void'(q.pop_front());
            if (m_acc && m_room) begin
                m_ent = '{code: in_code, brk: in_break, rpt: 1'b0};
                q.push_back(m_ent);
            end else if (!m_acc && m_fire && m_room) begin
                m_ent = '{code: m_rcode, brk: 1'b0, rpt: 1'b1};
                q.push_back(m_ent);
            end
            if (m_acc) m_kd[in_code] = !in_break;
            if (m_drop) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (live) begin
            hd = (q.size() != 0) ? q[0] : '0;
            check("out_valid", out_valid, q.size() != 0);
            check("out_code", out_code, hd.code);
            check("out_break", out_break, hd.brk);
            check("out_repeat", out_repeat, hd.rpt);
            check("level", level, q.size());
            check("key_down", key_down, m_kd);
            check("overflow", overflow, m_ovf);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [CODE_W-1:0] c, input logic b);
        in_valid = 1'b1; in_code = c; in_break = b;
        @(negedge clk);
        in_valid = 1'b0; in_code = '0; in_break = 1'b0;
    endtask

    task automatic wait_repeat(output int k, output logic [CODE_W-1:0] c);
        k = 0; c = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid && out_repeat) begin k = i; c = out_code; break; end
        end
    endtask

    initial begin
        int k, cnt;
        logic [CODE_W-1:0] c;
        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_break = 1'b0;
        repeat_en = 1'b0; clr_overflow = 1'b0; out_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_keys", key_down, 0);
        check("rst_ovf", overflow, 0);

        // make / break of 0x01C
        out_ready = 1'b1;
        send(9'h01C, 1'b0);
        check("t1_code", out_code, 9'h01C);
        check("t1_brk0", out_break, 0);
        check("t1_kd_set", key_down[9'h01C], 1);
        send(9'h01C, 1'b1);
        check("t1_brk1", out_break, 1);
        check("t1_kd_clr", key_down[9'h01C], 0);
        tick(1);
        check("t1_level0", level, 0);

        // extended key with a duplicate make
        send(9'h175, 1'b0);
        check("t2_kd_set", key_down[9'h175], 1);
        send(9'h175, 1'b0);
        check("t2_dup_drop", out_valid, 0);
        send(9'h175, 1'b1);
        check("t2_brk", {out_valid, out_break, out_code}, {2'b11, 9'h175});
        check("t2_kd_clr", key_down[9'h175], 0);
        tick(1);

        // auto-repeat of 0x01D
        repeat_en = 1'b1;
        send(9'h01D, 1'b0);
        wait_repeat(k, c);
        check("t3_first_gap", k, 20);
        check("t3_first_code", c, 9'h01D);
        wait_repeat(k, c);
        check("t3_rate_gap", k, 5);
        send(9'h01D, 1'b1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin tick(1); if (out_valid && out_repeat) cnt++; end
        check("t3_no_repeat", cnt, 0);
        repeat_en = 1'b0;

        // overflow with consumer stalled; set beats clear on the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(9'h010 + 9'(i), 1'b0);
        check("t4_full", level, 4);
        clr_overflow = 1'b1;
        send(9'h014, 1'b0);
        clr_overflow = 1'b0;
        check("t4_level", level, 4);
        check("t4_ovf", overflow, 1);
        check("t4_keys", $countones(key_down), 5);
        out_ready = 1'b1;
        send(9'h010, 1'b1);
        out_ready = 1'b0;
        check("t4_pp_level", level, 4);
        check("t4_pp_head", out_code, 9'h011);
        clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
        check("t4_ovf_clr", overflow, 0);
        out_ready = 1'b1;
        tick(5);
        check("t4_drained", level, 0);

        // repeat fire collides with a new make
        repeat_en = 1'b1;
        send(9'h01E, 1'b0);
        tick(19);
        send(9'h01B, 1'b0);
        check("t5_make_first", {out_valid, out_repeat, out_code}, {2'b10, 9'h01B});
        wait_repeat(k, c);
        check("t5_retarget_gap", k, 20);
        check("t5_retarget_code", c, 9'h01B);
        tick(4);
        send(9'h01E, 1'b1);
        check("t5_defer_brk", {out_break, out_code}, {1'b1, 9'h01E});
        tick(1);
        check("t5_defer_rpt", {out_repeat, out_code}, {1'b1, 9'h01B});
        send(9'h01B, 1'b1);
        tick(2);

        // reset with queued events and the generator mid-cadence
        out_ready = 1'b0;
        send(9'h01F, 1'b0);
        tick(25);
        check("t6_queued", level, 3);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        check("t6_valid", out_valid, 0);
        check("t6_level", level, 0);
        check("t6_keys", key_down, 0);
        check("t6_ovf", overflow, 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin tick(1); if (out_valid) cnt++; end
        check("t6_quiet", cnt, 0);

        // a repeat lost to a full FIFO does not flag overflow; a dropped break does
        send(9'h01F, 1'b0);
        tick(35);
        check("t7_level", level, 4);
        check("t7_ovf_lost_rpt", overflow, 0);
        send(9'h01F, 1'b1);
        check("t7_ovf_brk", overflow, 1);
        check("t7_keys", key_down, 0);
        check("t7_level_kept", level, 4);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
